// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave that turns single-beat transactions into accesses on a simple synchronous word-wide memory port.
// Define AXI4_LITE_MEM_BRIDGE_DECERR_EN to answer out-of-range addresses with DECERR instead of wrapping them.
`timescale 1ns/1ps
module axi4_lite_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [STROBE_WIDTH-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      mem_en,
  output logic [STROBE_WIDTH-1:0]   mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int         OFFS        = $clog2(STROBE_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WRITE_RESP, READ_WAIT, READ_RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  in_idle, wr_hs, rd_hs, wr_err, rd_err;
  logic                  unused_ok;

`ifdef AXI4_LITE_MEM_BRIDGE_DECERR_EN
  assign wr_err = (awaddr >> (OFFS + MEM_ADDR_WIDTH)) != '0;
  assign rd_err = (araddr >> (OFFS + MEM_ADDR_WIDTH)) != '0;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Protection bits carry no meaning here; the address bits outside the word index are dropped.
  assign unused_ok = ^{awprot, arprot, awaddr, araddr};

  // Gating with rst keeps the readies low for the whole reset, not just after the first edge.
  assign in_idle = (state_q == IDLE) && !rst;
  assign awready = in_idle && awvalid && wvalid;
  assign wready  = awready;
  assign arready = in_idle && !(awvalid && wvalid);
  assign wr_hs   = awready;
  assign rd_hs   = arready && arvalid;

  assign bvalid    = (state_q == WRITE_RESP);
  assign rvalid    = (state_q == READ_RESP);
  assign bresp     = bvalid ? resp_q : RESP_OKAY;
  assign rresp     = rvalid ? resp_q : RESP_OKAY;
  assign rdata     = rdata_q;
  assign mem_wdata = wdata;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = araddr[OFFS +: MEM_ADDR_WIDTH];
    case (state_q)
      IDLE: begin
        if (wr_hs) begin
          mem_en   = !wr_err;
          mem_we   = wr_err ? '0 : wstrb;
          mem_addr = awaddr[OFFS +: MEM_ADDR_WIDTH];
          resp_d   = wr_err ? RESP_DECERR : RESP_OKAY;
          state_d  = WRITE_RESP;
        end else if (rd_hs) begin
          mem_en  = !rd_err;
          resp_d  = rd_err ? RESP_DECERR : RESP_OKAY;
          state_d = READ_WAIT;
        end
      end
      WRITE_RESP: if (bready) state_d = IDLE;
      READ_WAIT: begin
        // The memory answers one cycle after the strobe; a decode error never touched it.
        rdata_d = (resp_q == RESP_OKAY) ? mem_rdata : '0;
        state_d = READ_RESP;
      end
      READ_RESP: if (rready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_bridge.sv
// Scoreboard bench for axi4_lite_mem_bridge: stimulus queues expected memory accesses and responses,
// an independent negedge monitor pops and compares them against a behavioural one-cycle memory.
`timescale 1ns/1ps
module tb_axi4_lite_mem_bridge;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, mem_wdata, mem_rdata = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic [3:0]  wstrb = 0, mem_we;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 0, arready, rvalid, rready = 1, mem_en;
  logic [9:0]  mem_addr;

  always #5 clk = ~clk;

  axi4_lite_mem_bridge dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {bit is_read; logic [1:0] resp; logic [31:0] data;} rsp_t;
  typedef struct {logic [3:0] we; logic [9:0] addr; bit chk_wdata; logic [31:0] wdata;} acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  int   checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  acc_t        a_m;
  rsp_t        r_m;
  int          rd_hs_cyc = 0;
  logic        rv_prev = 0, b_stall = 0, r_stall = 0;
  logic [1:0]  bresp_prev = 0, rresp_prev = 0;
  logic [31:0] rdata_prev = 0;

  always @(negedge clk) begin
    if (mem_en) begin
      if (acc_q.size() == 0) check("unexpected_mem_en", mem_en, 1'b0);
      else begin
        a_m = acc_q.pop_front();
        check("mem_we", mem_we, a_m.we);
        check("mem_addr", mem_addr, a_m.addr);
        if (a_m.chk_wdata) check("mem_wdata", mem_wdata, a_m.wdata);
      end
    end
    if (b_stall) begin
      check("b_stall_valid", bvalid, 1'b1);
      check("b_stall_resp", bresp, bresp_prev);
    end
    if (r_stall) begin
      check("r_stall_valid", rvalid, 1'b1);
      check("r_stall_resp", rresp, rresp_prev);
      check("r_stall_data", rdata, rdata_prev);
    end
    if (bvalid || rvalid) check("no_ready_while_busy", {awready, wready, arready}, 3'b000);
    if (arvalid && arready) rd_hs_cyc = cyc;
    if (rvalid && !rv_prev) check("ar_to_rvalid_latency", cyc - rd_hs_cyc, 2);
    rv_prev = rvalid;
    if ((bvalid && bready) || (rvalid && rready)) begin
      if (rsp_q.size() == 0) check("unexpected_response", {bvalid, rvalid}, 2'b00);
      else begin
        r_m = rsp_q.pop_front();
        check("resp_channel_is_read", rvalid, r_m.is_read);
        if (rvalid) begin
          check("rresp", rresp, r_m.resp);
          check("rdata", rdata, r_m.data);
        end else begin
          check("bresp", bresp, r_m.resp);
        end
      end
    end
    b_stall    = bvalid && !bready;
    r_stall    = rvalid && !rready;
    bresp_prev = bresp;
    rresp_prev = rresp;
    rdata_prev = rdata;
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int hold, input bit exp_acc,
                          input logic [9:0] exp_maddr, input logic [1:0] exp_resp);
    acc_t a;
    rsp_t r;
    int   n;
    if (exp_acc) begin
      a.we = strb; a.addr = exp_maddr; a.chk_wdata = 1'b1; a.wdata = data;
      acc_q.push_back(a);
    end
    r.is_read = 1'b0; r.resp = exp_resp; r.data = '0;
    rsp_q.push_back(r);
    awaddr = addr; wdata = data; wstrb = strb; awprot = prot;
    awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    check("aw_w_handshake", awready, 1'b1);
    check("write_mem_en", mem_en, exp_acc);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 bready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 20);
    check("b_handshake", bvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int hold,
                         input bit exp_acc, input logic [9:0] exp_maddr,
                         input logic [1:0] exp_resp, input logic [31:0] exp_data);
    acc_t a;
    rsp_t r;
    int   n;
    if (exp_acc) begin
      a.we = 4'h0; a.addr = exp_maddr; a.chk_wdata = 1'b0; a.wdata = '0;
      acc_q.push_back(a);
    end
    r.is_read = 1'b1; r.resp = exp_resp; r.data = exp_data;
    rsp_q.push_back(r);
    araddr = addr; arprot = prot; arvalid = 1'b1; rready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    check("ar_handshake", arready, 1'b1);
    check("read_mem_en", mem_en, exp_acc);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold + 1) @(posedge clk);
      #1 rready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 20);
    check("r_handshake", rvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    acc_t a;
    rsp_t r;
    int   n;

    // Reset: drive requests on both channels; nothing may be accepted.
    awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 32'h10; araddr = 32'h10; wstrb = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resps", {bresp, rresp}, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 4'h0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1 rst = 1'b0;

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1, 10'd4, OKAY);
    do_read (32'h10, 3'b000, 0, 1, 10'd4, OKAY, 32'hDEADBEEF);
    do_write(32'h24, 32'h11223344, 4'h5, 3'b111, 0, 1, 10'd9, OKAY);
    do_read (32'h24, 3'b101, 0, 1, 10'd9, OKAY, 32'h00220044);
    do_write(32'h28, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 1, 10'd10, OKAY);
    do_read (32'h28, 3'b000, 0, 1, 10'd10, OKAY, 32'h00000000);
    do_read (32'h13, 3'b000, 0, 1, 10'd4, OKAY, 32'hDEADBEEF);
    do_write(32'h00, 32'hCAFEF00D, 4'hF, 3'b000, 0, 1, 10'd0, OKAY);
`ifdef AXI4_LITE_MEM_BRIDGE_DECERR_EN
    do_read (32'h1000, 3'b000, 0, 0, 10'd0, DECERR, 32'h0);
    do_write(32'h1004, 32'h12345678, 4'hF, 3'b000, 0, 0, 10'd1, DECERR);
    do_read (32'h4, 3'b000, 0, 1, 10'd1, OKAY, 32'h0);
`else
    do_read (32'h1000, 3'b000, 0, 1, 10'd0, OKAY, 32'hCAFEF00D);
    do_write(32'h1004, 32'h12345678, 4'hF, 3'b000, 0, 1, 10'd1, OKAY);
    do_read (32'h4, 3'b000, 0, 1, 10'd1, OKAY, 32'h12345678);
`endif

    // Back-pressure on both response channels.
    do_write(32'h40, 32'hA5A5A5A5, 4'hF, 3'b000, 5, 1, 10'd16, OKAY);
    do_read (32'h40, 3'b000, 5, 1, 10'd16, OKAY, 32'hA5A5A5A5);

    // Simultaneous write and read: write wins, read follows the B handshake.
    a.we = 4'hF; a.addr = 10'd12; a.chk_wdata = 1'b1; a.wdata = 32'h0BADF00D; acc_q.push_back(a);
    a.we = 4'h0; a.addr = 10'd12; a.chk_wdata = 1'b0; a.wdata = '0;          acc_q.push_back(a);
    r.is_read = 1'b0; r.resp = OKAY; r.data = '0;           rsp_q.push_back(r);
    r.is_read = 1'b1; r.resp = OKAY; r.data = 32'h0BADF00D; rsp_q.push_back(r);
    awaddr = 32'h30; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 32'h30;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    check("prio_awready", awready, 1'b1);
    check("prio_arready", arready, 1'b0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    check("prio_read_accept_delay", n, 2);
    @(posedge clk); #1 arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 20);
    check("prio_r_handshake", rvalid, 1'b1);
    @(posedge clk); #1;

    // Reset during READ_WAIT drops the read without a response.
    a.we = 4'h0; a.addr = 10'd4; a.chk_wdata = 1'b0; a.wdata = '0; acc_q.push_back(a);
    araddr = 32'h10; arvalid = 1;
    @(negedge clk);
    check("midrst_ar_handshake", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0; rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", rvalid, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_arready", arready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_response", {bvalid, rvalid}, 2'b00);
    end
    @(posedge clk); #1;
    do_read(32'h30, 3'b000, 0, 1, 10'd12, OKAY, 32'h0BADF00D);

    repeat (3) @(posedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("acc_queue_drained", acc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
